// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: parallel PRBS generator and self-synchronising checker.
// Each step (i_enable && i_valid) advances the LFSR by DATA_WIDTH serial bits.
// Generator mode (i_mode=0) emits the pattern; checker mode (i_mode=1) locks
// onto i_data, tracks lock and accumulates a saturating bit-error count.
// Build macro PRBS_ERR_INJECT_EN adds i_err_inject, which inverts o_data[0]
// of a generated word without disturbing the LFSR.
module prbs_gen_chk #(
  parameter int unsigned       N_BITS     = 31,
  parameter int unsigned       EXP1       = 30,
  parameter int unsigned       EXP2       = 27,
  parameter logic [N_BITS-1:0] SEED       = 31'h7FFFFFFF,
  parameter int unsigned       DATA_WIDTH = 64,
  parameter int unsigned       LOCK_CNT   = 4,
  parameter int unsigned       UNLOCK_CNT = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic                  i_mode,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_clear_err,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                  i_err_inject,
`endif
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_lock,
  output logic                  o_err_flag,
  output logic [31:0]           o_err_count
);

  localparam int unsigned EW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_CNT - 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Serial Fibonacci recurrence unrolled DATA_WIDTH times; first bit lands in the MSB.
  function automatic logic [DATA_WIDTH-1:0] lfsr_word(input logic [N_BITS-1:0] s_in);
    logic [N_BITS-1:0]     s;
    logic [DATA_WIDTH-1:0] w;
    logic                  b;
    s = s_in;
    w = '0;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      b = s[EXP1] ^ s[EXP2];
      s = {s[N_BITS-2:0], b};
      w[DATA_WIDTH-1-k] = b;
    end
    return w;
  endfunction

  logic [N_BITS-1:0]     lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [0:0]            fsm_q, fsm_d;
  logic [MW-1:0]         match_q, match_d;
  logic [BW-1:0]         bad_q, bad_d;
  logic                  flag_q, flag_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  mode_q;

  logic                  step_w;
  logic                  mode_chg_w;
  logic                  inj_w;
  logic [DATA_WIDTH-1:0] word_w;
  logic [DATA_WIDTH-1:0] diff_w;
  logic [EW-1:0]         err_bits_w;
  logic [32:0]           sum_w;

  assign step_w     = i_enable & i_valid;
  assign mode_chg_w = i_mode ^ mode_q;
  assign word_w     = lfsr_word(lfsr_q);
  assign diff_w     = i_data ^ word_w;
  assign err_bits_w = EW'($countones(diff_w));
  assign sum_w      = {1'b0, cnt_q} + {{(33 - EW){1'b0}}, err_bits_w};

`ifdef PRBS_ERR_INJECT_EN
  assign inj_w = i_err_inject;
`else
  assign inj_w = 1'b0;
`endif

  // Next-state logic for generator datapath, checker FSM and error counter.
  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = step_w & ~i_mode;
    fsm_d   = fsm_q;
    match_d = match_q;
    bad_d   = bad_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;

    if (step_w) begin
      if (!i_mode) begin
        lfsr_d = word_w[N_BITS-1:0];
        data_d = word_w ^ {{(DATA_WIDTH - 1){1'b0}}, inj_w};
      end else if (fsm_q == ST_SEARCH) begin
        lfsr_d = i_data[N_BITS-1:0];
        if (err_bits_w == '0) begin
          if (match_q == MATCH_LAST) begin
            fsm_d   = ST_LOCKED;
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end else begin
          match_d = '0;
        end
      end else begin
        lfsr_d = word_w[N_BITS-1:0];
        cnt_d  = sum_w[32] ? '1 : sum_w[31:0];
        flag_d = (err_bits_w != '0);
        if (err_bits_w != '0) begin
          if (bad_q == BAD_LAST) begin
            fsm_d = ST_SEARCH;
            bad_d = '0;
          end else begin
            bad_d = bad_q + 1'b1;
          end
        end else begin
          bad_d = '0;
        end
      end
    end

    // A mode switch restarts acquisition but keeps the LFSR and error count.
    if (mode_chg_w) begin
      fsm_d   = ST_SEARCH;
      match_d = '0;
      bad_d   = '0;
    end

    if (i_clear_err) begin
      cnt_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      lfsr_q  <= SEED;
      data_q  <= '0;
      valid_q <= 1'b0;
      fsm_q   <= ST_SEARCH;
      match_q <= '0;
      bad_q   <= '0;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fsm_q   <= fsm_d;
      match_q <= match_d;
      bad_q   <= bad_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      mode_q  <= i_mode;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_lock      = (fsm_q == ST_LOCKED);
  assign o_err_flag  = flag_q;
  assign o_err_count = cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: generator instance looped into a checker instance, with a
// bit-history reference model of the PRBS sequence and a behavioural checker model.
`timescale 1ns/1ps
module tb_prbs_gen_chk;

  localparam int unsigned NB = 31;
  localparam int unsigned DW = 64;
  localparam int unsigned E1 = 30;
  localparam int unsigned E2 = 27;
  localparam int unsigned LC = 4;
  localparam int unsigned UC = 4;
  localparam logic [NB-1:0] SEED = 31'h7FFFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          g_valid = 1'b0;
  logic          c_gate = 1'b0;
  logic          c_clear = 1'b0;
  logic          zero_word = 1'b0;
  logic          inj = 1'b0;
  logic [DW-1:0] mask = '0;

  logic [DW-1:0] g_data, c_data, c_din;
  logic          g_vo, c_vo, g_lock, c_lock, g_flag, c_flag, c_valid;
  logic [31:0]   g_cnt, c_cnt;

  assign c_din   = zero_word ? '0 : (g_data ^ mask);
  assign c_valid = g_vo & c_gate;

  always #5 clk = ~clk;

  prbs_gen_chk #(.N_BITS(NB), .EXP1(E1), .EXP2(E2), .SEED(SEED),
                 .DATA_WIDTH(DW), .LOCK_CNT(LC), .UNLOCK_CNT(UC)) u_gen (
    .i_clock(clk), .i_reset(rst), .i_enable(1'b1), .i_valid(g_valid),
    .i_mode(1'b0), .i_data({DW{1'b0}}), .i_clear_err(1'b0),
`ifdef PRBS_ERR_INJECT_EN
    .i_err_inject(inj),
`endif
    .o_data(g_data), .o_valid(g_vo), .o_lock(g_lock), .o_err_flag(g_flag),
    .o_err_count(g_cnt)
  );

  prbs_gen_chk #(.N_BITS(NB), .EXP1(E1), .EXP2(E2), .SEED(SEED),
                 .DATA_WIDTH(DW), .LOCK_CNT(LC), .UNLOCK_CNT(UC)) u_chk (
    .i_clock(clk), .i_reset(rst), .i_enable(1'b1), .i_valid(c_valid),
    .i_mode(1'b1), .i_data(c_din), .i_clear_err(c_clear),
`ifdef PRBS_ERR_INJECT_EN
    .i_err_inject(1'b0),
`endif
    .o_data(c_data), .o_valid(c_vo), .o_lock(c_lock), .o_err_flag(c_flag),
    .o_err_count(c_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [NB-1:0] gm_state;
  logic [DW-1:0] gm_data;
  logic          gm_valid;
  logic [NB-1:0] cm_state;
  logic          cm_lock, cm_flag;
  int unsigned   cm_match, cm_bad;
  logic [31:0]   cm_cnt;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Sequence bit b[n] = b[n-1-E1] ^ b[n-1-E2], with the state holding the last NB bits.
  function automatic logic [DW-1:0] model_word(input logic [NB-1:0] st);
    bit            hist[$];
    logic [DW-1:0] w;
    bit            b;
    for (int j = 0; j < NB; j++) hist.push_back(st[NB-1-j]);
    w = '0;
    for (int k = 0; k < DW; k++) begin
      b = hist[NB-1-E1] ^ hist[NB-1-E2];
      hist.push_back(b);
      void'(hist.pop_front());
      w[DW-1-k] = b;
    end
    return w;
  endfunction

  task automatic check_all();
    check("g_valid", 64'(g_vo), 64'(gm_valid));
    check("g_data", g_data, gm_data);
    check("g_side", {61'b0, g_lock, g_flag, |g_cnt}, 64'd0);
    check("c_valid", 64'(c_vo), 64'd0);
    check("c_data", c_data, 64'd0);
    check("c_lock", 64'(c_lock), 64'(cm_lock));
    check("c_flag", 64'(c_flag), 64'(cm_flag));
    check("c_cnt", 64'(c_cnt), 64'(cm_cnt));
  endtask

  task automatic cycle(input logic gstep);
    logic          cstep, clr;
    logic [DW-1:0] cin, w, pred;
    logic [32:0]   s;
    int            e;
    g_valid = gstep;
    cstep   = gm_valid & c_gate;
    cin     = zero_word ? '0 : (gm_data ^ mask);
    clr     = c_clear;
    @(posedge clk);
    if (gstep) begin
      w        = model_word(gm_state);
      gm_state = w[NB-1:0];
      gm_data  = w ^ {{(DW-1){1'b0}}, inj};
      gm_valid = 1'b1;
    end else begin
      gm_valid = 1'b0;
    end
    if (cstep) begin
      pred = model_word(cm_state);
      e    = $countones(cin ^ pred);
      if (!cm_lock) begin
        cm_state = cin[NB-1:0];
        if (e == 0) begin
          cm_match++;
          if (cm_match == LC) begin cm_lock = 1'b1; cm_match = 0; end
        end else cm_match = 0;
      end else begin
        cm_state = pred[NB-1:0];
        s        = {1'b0, cm_cnt} + 33'(e);
        cm_cnt   = s[32] ? 32'hFFFF_FFFF : s[31:0];
        cm_flag  = (e != 0);
        if (e != 0) begin
          cm_bad++;
          if (cm_bad == UC) begin cm_lock = 1'b0; cm_bad = 0; end
        end else cm_bad = 0;
      end
    end
    if (clr) cm_cnt = '0;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    g_valid = 1'b0; c_gate = 1'b0; mask = '0; zero_word = 1'b0; c_clear = 1'b0; inj = 1'b0;
    rst = 1'b1;
    #1;
    gm_state = SEED; gm_data = '0; gm_valid = 1'b0;
    cm_state = SEED; cm_lock = 1'b0; cm_flag = 1'b0; cm_match = 0; cm_bad = 0; cm_cnt = '0;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            vcount, n, gap, p;
    logic          st;
    logic [DW-1:0] m;
    logic [DW-1:0] first_exp;

    @(negedge clk);

    // Three generator steps from SEED.
    do_reset();
    first_exp = model_word(SEED);
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1);
      if (g_vo) vcount++;
      if (i == 0) check("first_word", g_data, first_exp);
      check("state_chain", 64'(g_data[NB-1:0]), 64'(gm_state));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      if (g_vo) vcount++;
    end
    check("valid_cycles", 64'(vcount), 64'd3);

    // Loopback lock from SEED, then 1000 words with random idle cycles.
    do_reset();
    c_gate = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1);
      if (i == 4) check("lock_after3", 64'(c_lock), 64'd0);
      if (i == 5) check("lock_after4", 64'(c_lock), 64'd1);
    end
    n = 0;
    while (n < 1000) begin
      st = ($urandom_range(0, 3) != 0);
      cycle(st);
      if (st) n++;
    end
    check("loop_errs", 64'(c_cnt), 64'd0);
    check("loop_lock", 64'(c_lock), 64'd1);

    // Three bit flips in a single word.
    cycle(1'b1);
    m = '0;
    while ($countones(m) < 3) begin
      p = $urandom_range(0, DW - 1);
      m[p] = 1'b1;
    end
    mask = m;
    cycle(1'b1);
    mask = '0;
    check("flip3_cnt", 64'(c_cnt), 64'd3);
    check("flip3_flag", 64'(c_flag), 64'd1);
    check("flip3_lock", 64'(c_lock), 64'd1);
    cycle(1'b1);
    check("flip3_flag_clr", 64'(c_flag), 64'd0);

    // Sparse random single-bit errors, then a clean stretch.
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, DW - 1);
      m = '0;
      if ($urandom_range(0, 2) == 0) m[p] = 1'b1;
      mask = m;
      cycle(1'b1);
    end
    mask = '0;
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check("relock", 64'(c_lock), 64'd1);

    // Four all-zero words drop lock; resume at a random phase.
    zero_word = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1);
      if (i == 3) check("zero3_lock", 64'(c_lock), 64'd1);
      if (i == 4) check("zero4_lock", 64'(c_lock), 64'd0);
    end
    zero_word = 1'b0;
    c_gate = 1'b0;
    gap = $urandom_range(1, 20);
    for (int i = 0; i < gap; i++) cycle(1'b1);
    c_gate = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1);
      check("resync_lock", 64'(c_lock), (i == 5) ? 64'd1 : 64'd0);
    end

    // Saturation from a preloaded count, then clear colliding with an error.
    cycle(1'b0);
    force u_chk.cnt_q = 32'hFFFF_FF00;
    cm_cnt = 32'hFFFF_FF00;
    cycle(1'b0);
    release u_chk.cnt_q;
    cycle(1'b1);
    for (int r = 0; r < 3; r++) begin
      mask = '1;
      for (int i = 0; i < 3; i++) cycle(1'b1);
      mask = '0;
      cycle(1'b1);
    end
    check("sat_cnt", 64'(c_cnt), 64'hFFFF_FFFF);
    check("sat_lock", 64'(c_lock), 64'd1);
    c_clear = 1'b1;
    mask = '1;
    cycle(1'b1);
    c_clear = 1'b0;
    mask = '0;
    check("clear_cnt", 64'(c_cnt), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1);

`ifdef PRBS_ERR_INJECT_EN
    // Single injected error in the generated stream.
    inj = 1'b1;
    cycle(1'b1);
    inj = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1);
    check("inj_cnt", 64'(c_cnt), 64'd1);
    check("inj_lock", 64'(c_lock), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_gen_chk.md
# prbs_gen_chk

Parallel PRBS generator and self-synchronising checker for the frame generator and lane test path. The LFSR polynomial is parametrised and the block advances DATA_WIDTH sequence bits per clock. In generator mode it drives a pattern word every valid cycle. In checker mode it locks onto an incoming pattern, tracks lock with a state machine and counts bit errors.

## Interface
- N_BITS, 31: LFSR length.
- EXP1, 30: first feedback tap index.
- EXP2, 27: second feedback tap index. The default polynomial is x^31+x^28+1.
- SEED, 31'h7FFFFFFF: LFSR reset value. Must be non-zero.
- DATA_WIDTH, 64: bits per word. Must be ≥ N_BITS.
- LOCK_CNT, 4: consecutive matching words needed to lock.
- UNLOCK_CNT, 4: consecutive errored words needed to drop lock.
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  block enable.
- i_valid  in  1  word strobe. The block advances only when i_enable && i_valid (the "step").
- i_mode  in  1  0 = generate, 1 = check.
- i_data  in  DATA_WIDTH  received word (checker).
- i_clear_err  in  1  synchronous clear of the error counter.
- o_data  out  DATA_WIDTH  generated word.
- o_valid  out  1  o_data valid.
- o_lock  out  1  checker locked.
- o_err_flag  out  1  last checked word had at least one error while locked.
- o_err_count  out  32  saturating bit-error count.

## Operation
- Serial recurrence: new bit = s[EXP1] ^ s[EXP2]; s shifts left with the new bit at s[0].
- One step computes DATA_WIDTH serial bits b0..bW-1 combinationally.
  - Bit mapping: o_data[W-1-k] = bk, so the MSB is the first bit.
  - After the step the state holds the last N_BITS bits, so the next state = word[N_BITS-1:0].
- Generator (i_mode=0):
  - Each step: o_data <= next word, state <= next word[N_BITS-1:0], o_valid <= 1.
  - Any non-step cycle: o_valid <= 0 and o_data holds its value.
- Checker (i_mode=1):
  - The predicted word is computed from the state.
  - e = popcount(i_data ^ predicted).
  - o_valid stays 0 in this mode.
- Checker FSM, SEARCH (the reset state):
  - Each step: state <= i_data[N_BITS-1:0].
  - If e==0, match_cnt++. Otherwise match_cnt <= 0.
  - When match_cnt reaches LOCK_CNT, go to LOCKED, set o_lock=1 and clear match_cnt.
  - Errors are not counted in SEARCH.
- Checker FSM, LOCKED:
  - Each step: state <= predicted[N_BITS-1:0]. The checker free-runs and does not reload from i_data.
  - o_err_count <= min(o_err_count + e, 2^32-1).
  - o_err_flag <= (e != 0).
  - If e != 0, bad_cnt++. Otherwise bad_cnt <= 0.
  - When bad_cnt reaches UNLOCK_CNT, go to SEARCH, set o_lock=0 and clear bad_cnt.
- A change of i_mode (registered edge detect) forces SEARCH and clears match_cnt and bad_cnt. The LFSR state and the error counter are kept.
- i_clear_err zeroes o_err_count. If it coincides with an increment, the clear wins.

## Timing
- All outputs are registered, with latency 1 clock from the step.
- Reset values: state = SEED, o_data = 0, o_valid = 0, o_lock = 0, o_err_flag = 0, o_err_count = 0, FSM = SEARCH, and both counters 0.
- Reset is asynchronous. Asserting it mid-word aborts the word with no partial update.
- With i_enable=0 or i_valid=0, all state holds.
- o_lock rises in the cycle after the LOCK_CNT-th consecutive matching step. It falls in the cycle after the UNLOCK_CNT-th consecutive errored step.
- o_err_count saturates at 32'hFFFFFFFF and does not wrap.

## Configuration
- PRBS_ERR_INJECT_EN defined:
  - Adds port i_err_inject (in, 1).
  - On a generator step with i_err_inject=1, o_data[0] is inverted in the output only. The LFSR state uses the uncorrupted word.
- Not defined: the port is absent and the output is never corrupted.

## Test plan
- Reset, then 3 generator steps with the defaults: the first o_data equals the 64-bit software model from SEED 31'h7FFFFFFF, and every word[30:0] equals the next model state. o_valid is high for exactly 3 cycles.
- Loopback, generator to checker, both from SEED: o_lock=1 in the cycle after the 4th step, and o_err_count stays 0 over 1000 words.
- While locked, flip 3 bits in a single word: o_err_count=3, o_err_flag=1 for that word then 0, and o_lock stays 1.
- While locked, feed 4 consecutive all-zero words: o_lock drops after the 4th. Then resume a clean stream at an arbitrary phase: o_lock=1 after the 4th clean matching word following the first reseed word.
- Preload o_err_count near saturation with a continuous error stream: it holds at 32'hFFFFFFFF. Assert i_clear_err together with an error: the count becomes 0.
- With PRBS_ERR_INJECT_EN, pulse i_err_inject once in loopback: the checker counts exactly 1 error and stays locked.
